// File: rtl/nkmm_prog_loader.sv
// Boot loader: length header + big-endian words into pmem, CPU held in reset until done.
// Optional trailing XOR checksum byte when NKMM_LOADER_CHECKSUM_EN is defined.
module nkmm_prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int INSN_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  pmem_we_o,
    output logic [ADDR_WIDTH-1:0] pmem_addr_o,
    output logic [INSN_WIDTH-1:0] pmem_data_o,
    output logic                  cpu_rst_o,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERROR
    } state_e;

    localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [23:0]           asm_q, asm_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSN_WIDTH-1:0] data_q, data_d;
    logic                  rx_q, rx_d;
    logic                  crst_q, crst_d;
    logic                  err_q, err_d;
    logic                  xfer;
    logic [15:0]           len_full;
    state_e                done_st;
`ifdef NKMM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    assign done_st = S_CSUM;
`else
    assign done_st = S_RUN;
`endif

    assign xfer     = byte_valid_i & rx_q;
    assign len_full = {len_q[15:8], byte_i};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef NKMM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (xfer && state_q != S_CSUM) begin
            csum_d = csum_q ^ byte_i;
        end
`endif
        unique case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    bcnt_d  = '0;
                    wcnt_d  = '0;
`ifdef NKMM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_i;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = done_st;
                    end else if ({1'b0, len_full} > 17'(MAX_WORDS)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d  = {asm_q[15:0], byte_i};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = wcnt_q[ADDR_WIDTH-1:0];
                        data_d = INSN_WIDTH'({asm_q, byte_i});
                        wcnt_d = wcnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                        if (17'(wcnt_d) == {1'b0, len_q}) begin
                            state_d = done_st;
                        end
                    end
                end
            end
`ifdef NKMM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = (byte_i == csum_q) ? S_RUN : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Release the CPU only once RUN has been held for a full cycle.
    assign rx_d   = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    assign crst_d = !(state_q == S_RUN && state_d == S_RUN);
    assign err_d  = state_d == S_ERROR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            asm_q   <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rx_q    <= 1'b0;
            crst_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef NKMM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rx_q    <= rx_d;
            crst_q  <= crst_d;
            err_q   <= err_d;
`ifdef NKMM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign byte_ready_o = rx_q;
    assign busy_o       = rx_q;
    assign pmem_we_o    = we_q;
    assign pmem_addr_o  = addr_q;
    assign pmem_data_o  = data_q;
    assign cpu_rst_o    = crst_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_nkmm_prog_loader.sv
// Directed bench for nkmm_prog_loader (ADDR_WIDTH=8, max 256 words).
// Tracks the running XOR so checksum builds exercise the same flows.
module tb_nkmm_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  byte_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        pmem_we_o;
    logic [7:0]  pmem_addr_o;
    logic [31:0] pmem_data_o;
    logic        cpu_rst_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    logic [7:0]  cs;
    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    nkmm_prog_loader #(.ADDR_WIDTH(8), .INSN_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o), .pmem_we_o(pmem_we_o),
        .pmem_addr_o(pmem_addr_o), .pmem_data_o(pmem_data_o),
        .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pmem_we_o) begin
            wq_addr.push_back(pmem_addr_o);
            wq_data.push_back(pmem_data_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cs = 8'h00;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_i = b;
        byte_valid_i = 1'b1;
        n = 0;
        while (!byte_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rdy", {31'd0, byte_ready_o}, 32'd1);
        @(posedge clk);
        #1 byte_valid_i = 1'b0;
        cs = cs ^ b;
    endtask

    task automatic send_csum();
`ifdef NKMM_LOADER_CHECKSUM_EN
        send(cs, 0);
`endif
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cs = 8'h00;
        // 1: reset state and single word load
        repeat (3) @(negedge clk);
        chk("rst_cpu", {31'd0, cpu_rst_o}, 32'd1);
        chk("rst_rdy", {31'd0, byte_ready_o}, 32'd0);
        chk("rst_we", {31'd0, pmem_we_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_data", pmem_data_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy", {31'd0, byte_ready_o}, 32'd0);
        pulse_start();
        chk("t1_busy", {31'd0, busy_o}, 32'd1);
        send(8'h00, 0); send(8'h01, 0);
        send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
        send_csum();
        @(negedge clk);
        chk("t1_we", {31'd0, pmem_we_o}, 32'd1);
        chk("t1_cpu_k1", {31'd0, cpu_rst_o}, 32'd1);
        @(negedge clk);
        chk("t1_cpu_k2", {31'd0, cpu_rst_o}, 32'd0);
        chk("t1_we_off", {31'd0, pmem_we_o}, 32'd0);
        chk("t1_busy_off", {31'd0, busy_o}, 32'd0);
        chk("t1_nwr", wq_data.size(), 32'd1);
        if (wq_data.size() == 1) begin
            chk("t1_addr", {24'd0, wq_addr[0]}, 32'd0);
            chk("t1_data", wq_data[0], 32'hDEADBEEF);
        end

        // 2: restart from RUN, 3 words with gaps, start while busy ignored
        clear_q();
        pulse_start();
        chk("t2_cpu", {31'd0, cpu_rst_o}, 32'd1);
        send(8'h00, 1); send(8'h03, 2);
        send(8'h01, 0); send(8'h02, 3); send(8'h03, 1); send(8'h04, 0);
        pulse_start();
        cs = 8'h03 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04;
        send(8'h11, 2); send(8'h22, 0); send(8'h33, 1); send(8'h44, 3);
        send(8'hA5, 0); send(8'hA5, 2); send(8'h5A, 1); send(8'h5A, 0);
        send_csum();
        repeat (3) @(negedge clk);
        chk("t2_cpu_run", {31'd0, cpu_rst_o}, 32'd0);
        chk("t2_nwr", wq_data.size(), 32'd3);
        if (wq_data.size() == 3) begin
            chk("t2_a0", {24'd0, wq_addr[0]}, 32'd0);
            chk("t2_a1", {24'd0, wq_addr[1]}, 32'd1);
            chk("t2_a2", {24'd0, wq_addr[2]}, 32'd2);
            chk("t2_d0", wq_data[0], 32'h01020304);
            chk("t2_d1", wq_data[1], 32'h11223344);
            chk("t2_d2", wq_data[2], 32'hA5A55A5A);
        end

        // 3: oversize length 257 -> ERROR
        clear_q();
        pulse_start();
        send(8'h01, 0); send(8'h01, 0);
        @(negedge clk);
        chk("t3_err", {31'd0, err_o}, 32'd1);
        chk("t3_busy", {31'd0, busy_o}, 32'd0);
        chk("t3_rdy", {31'd0, byte_ready_o}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_cpu", {31'd0, cpu_rst_o}, 32'd1);
        chk("t3_nwr", wq_data.size(), 32'd0);
        pulse_start();
        chk("t3_err_clr", {31'd0, err_o}, 32'd0);
        chk("t3_busy2", {31'd0, busy_o}, 32'd1);

        // 4: len 0 -> RUN, then restart from RUN with len 0
        send(8'h00, 0); send(8'h00, 0);
        send_csum();
        repeat (2) @(negedge clk);
        chk("t4_run", {31'd0, cpu_rst_o}, 32'd0);
        pulse_start();
        chk("t4_rerst", {31'd0, cpu_rst_o}, 32'd1);
        send(8'h00, 0); send(8'h00, 0);
        send_csum();
        repeat (2) @(negedge clk);
        chk("t4_rel", {31'd0, cpu_rst_o}, 32'd0);
        chk("t4_nwr", wq_data.size(), 32'd0);

`ifdef NKMM_LOADER_CHECKSUM_EN
        // 5: checksum match / mismatch (XOR 00^01^11^22^33^44 = 45)
        pulse_start();
        send(8'h00, 0); send(8'h01, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h45, 0);
        repeat (2) @(negedge clk);
        chk("t5_ok_cpu", {31'd0, cpu_rst_o}, 32'd0);
        chk("t5_ok_err", {31'd0, err_o}, 32'd0);
        pulse_start();
        send(8'h00, 0); send(8'h01, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h44, 0);
        repeat (2) @(negedge clk);
        chk("t5_bad_err", {31'd0, err_o}, 32'd1);
        chk("t5_bad_cpu", {31'd0, cpu_rst_o}, 32'd1);
        chk("t5_nwr", wq_data.size(), 32'd2);
        clear_q();
`endif

        // 6: len 256 accepted, async reset mid-load, then clean reload
        pulse_start();
        send(8'h01, 0); send(8'h00, 0);
        @(negedge clk);
        chk("t6_len256_err", {31'd0, err_o}, 32'd0);
        chk("t6_len256_busy", {31'd0, busy_o}, 32'd1);
        send(8'h12, 0); send(8'h34, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rdy", {31'd0, byte_ready_o}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_rst_cpu", {31'd0, cpu_rst_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        pulse_start();
        send(8'h00, 0); send(8'h01, 0);
        send(8'hCA, 0); send(8'hFE, 0); send(8'hBA, 0); send(8'hBE, 0);
        send_csum();
        repeat (3) @(negedge clk);
        chk("t6_nwr", wq_data.size(), 32'd1);
        if (wq_data.size() == 1) begin
            chk("t6_addr", {24'd0, wq_addr[0]}, 32'd0);
            chk("t6_data", wq_data[0], 32'hCAFEBABE);
        end
        chk("t6_cpu", {31'd0, cpu_rst_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
